// File: rtl/csr_trap_unit_pkg.sv
// csr_trap_unit_pkg: CSR addresses, exception bits, mcause codes and FSM states
package csr_trap_unit_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam int EXC_ECALL   = 0;
  localparam int EXC_EBREAK  = 1;
  localparam int EXC_ILLEGAL = 2;
  localparam int EXC_MRET    = 3;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  typedef enum logic [1:0] {IDLE, TRAP_JUMP, MRET_JUMP} state_t;
endpackage

// File: rtl/csr_trap_unit_if.sv
// csr_trap_unit_if: pipeline-side CSR access, exception and trap redirect signals
interface csr_trap_unit_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [31:0] exception;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        irq_timer;
  logic        irq_ext;
  logic        stallreq;
  logic        flush;
  logic        trap_jump_enable;
  logic [31:0] trap_jump_addr;
  modport master (
    output csr_raddr, csr_we, csr_waddr, csr_wdata, exception, inst_valid, inst_addr,
           irq_timer, irq_ext,
    input  csr_rdata, stallreq, flush, trap_jump_enable, trap_jump_addr
  );
  modport slave (
    input  csr_raddr, csr_we, csr_waddr, csr_wdata, exception, inst_valid, inst_addr,
           irq_timer, irq_ext,
    output csr_rdata, stallreq, flush, trap_jump_enable, trap_jump_addr
  );
endinterface

// File: rtl/csr_trap_unit_cycle_counter.sv
// csr_trap_unit_cycle_counter: free-running 64-bit cycle counter with per-half load
module csr_trap_unit_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (we_lo) count[31:0] <= wdata;
    else if (we_hi) count[63:32] <= wdata;
    else count <= count + 64'd1;
  end
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with trap entry / MRET controller
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  csr_trap_unit_if.slave bus
);
  state_t state, state_nxt;
  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec, mscratch, mepc, mcause, mtval, mip, mstatus, pend, cause;
  logic [63:0] mcycle;
  logic [3:0]  exc;
  logic        idle_valid, is_exc, irq, take_trap, take_mret, jump, unused_bits;
  assign exc         = bus.exception[3:0];
  assign unused_bits = ^bus.exception[31:4];
  assign mip         = {20'b0, bus.irq_ext, 3'b0, bus.irq_timer, 7'b0};
  assign mstatus     = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
  assign pend        = mie_q & mip;
  always_comb begin
    case (bus.csr_raddr)
      CSR_MSTATUS:  bus.csr_rdata = mstatus;
      CSR_MIE:      bus.csr_rdata = mie_q;
      CSR_MTVEC:    bus.csr_rdata = mtvec;
      CSR_MSCRATCH: bus.csr_rdata = mscratch;
      CSR_MEPC:     bus.csr_rdata = mepc;
      CSR_MCAUSE:   bus.csr_rdata = mcause;
      CSR_MTVAL:    bus.csr_rdata = mtval;
      CSR_MIP:      bus.csr_rdata = mip;
      CSR_MCYCLE:   bus.csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:  bus.csr_rdata = mcycle[63:32];
      CSR_MHARTID:  bus.csr_rdata = MHARTID;
      default:      bus.csr_rdata = '0;
    endcase
  end
  // Decisions are only made from IDLE; the jump states ignore exceptions and IRQs.
  assign idle_valid = state == IDLE && bus.inst_valid && !rst;
  assign is_exc     = exc[EXC_ILLEGAL] | exc[EXC_EBREAK] | exc[EXC_ECALL];
  assign irq        = mst_mie && pend != '0;
  assign take_trap  = idle_valid && (is_exc || (!exc[EXC_MRET] && irq));
  assign take_mret  = idle_valid && !is_exc && exc[EXC_MRET];
  assign cause      = exc[EXC_ILLEGAL] ? CAUSE_ILLEGAL :
                      exc[EXC_EBREAK]  ? CAUSE_EBREAK  :
                      exc[EXC_ECALL]   ? CAUSE_ECALL   :
                      pend[11]         ? CAUSE_IRQ_EXT : CAUSE_IRQ_TMR;
  always_comb begin
    state_nxt            = take_trap ? TRAP_JUMP : take_mret ? MRET_JUMP : IDLE;
    jump                 = !rst && state != IDLE;
    bus.stallreq         = take_trap | take_mret;
    bus.flush            = jump;
    bus.trap_jump_enable = jump;
    bus.trap_jump_addr   = !jump ? '0 : state == TRAP_JUMP ? mtvec : mepc;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  // Trap and MRET updates are placed last so they override a same-cycle CSR write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mie_q    <= '0;
      mtvec    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else begin
      if (bus.csr_we) begin
        case (bus.csr_waddr)
          CSR_MSTATUS: begin
            mst_mie  <= bus.csr_wdata[3];
            mst_mpie <= bus.csr_wdata[7];
          end
          CSR_MIE:      mie_q    <= bus.csr_wdata & MIE_MASK;
          CSR_MTVEC:    mtvec    <= {bus.csr_wdata[31:2], 2'b00};
          CSR_MSCRATCH: mscratch <= bus.csr_wdata;
          CSR_MEPC:     mepc     <= {bus.csr_wdata[31:2], 2'b00};
          CSR_MCAUSE:   mcause   <= bus.csr_wdata;
          CSR_MTVAL:    mtval    <= bus.csr_wdata;
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc     <= {bus.inst_addr[31:2], 2'b00};
        mcause   <= cause;
        mtval    <= '0;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end
      if (take_mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end
    end
  end
  csr_trap_unit_cycle_counter u_cycle (
    .clk   (clk),
    .rst   (rst),
    .we_lo (bus.csr_we && bus.csr_waddr == CSR_MCYCLE),
    .we_hi (bus.csr_we && bus.csr_waddr == CSR_MCYCLEH),
    .wdata (bus.csr_wdata),
    .count (mcycle)
  );
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed + random stimulus against a CSR/trap reference model, queue scoreboard
module tb_csr_trap_unit;
  localparam logic [31:0] TV   = 32'h0000_0200;
  localparam logic [31:0] HART = 32'h0000_0003;
  typedef struct {
    logic [31:0] rdata;
    logic        stall, flush, jen;
    logic [31:0] jaddr;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int errs = 0;
  exp_t q[$];
  logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'hB00, 12'hB80, 12'hF14, 12'h7C0, 12'h301};
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  logic [63:0] m_cyc;
  int          mode;
  always #5 clk = ~clk;
  csr_trap_unit_if bus();
  csr_trap_unit #(.MTVEC_RESET(TV), .MHARTID(HART)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic mreset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = TV; m_scratch = 0;
    m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; mode = 0;
  endtask

  function automatic logic [31:0] rd(input logic [11:0] a, input logic ti, input logic te);
    case (a)
      12'h300: rd = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: rd = m_ie;
      12'h305: rd = m_tvec;
      12'h340: rd = m_scratch;
      12'h341: rd = m_epc;
      12'h342: rd = m_cause;
      12'h343: rd = m_tval;
      12'h344: rd = (32'(te) << 11) | (32'(ti) << 7);
      12'hB00: rd = m_cyc[31:0];
      12'hB80: rd = m_cyc[63:32];
      12'hF14: rd = HART;
      default: rd = 0;
    endcase
  endfunction

  task automatic go(input logic r, input logic [11:0] ra, input logic we, input logic [11:0] wa,
                    input logic [31:0] wd, input logic [31:0] ex, input logic v,
                    input logic [31:0] pc, input logic ti, input logic te);
    exp_t e;
    logic trap, mret, old_mie, old_mpie;
    logic [31:0] code, pend;
    @(posedge clk); #1;
    rst = r; bus.csr_raddr = ra; bus.csr_we = we; bus.csr_waddr = wa; bus.csr_wdata = wd;
    bus.exception = ex; bus.inst_valid = v; bus.inst_addr = pc; bus.irq_timer = ti; bus.irq_ext = te;
    pend = m_ie & ((32'(te) << 11) | (32'(ti) << 7));
    trap = 0; mret = 0; code = 0;
    if (!r && mode == 0 && v) begin
      if (ex[2]) begin trap = 1; code = 2; end
      else if (ex[1]) begin trap = 1; code = 3; end
      else if (ex[0]) begin trap = 1; code = 11; end
      else if (ex[3]) mret = 1;
      else if (m_mie && pend != 0) begin trap = 1; code = pend[11] ? 32'h8000_000B : 32'h8000_0007; end
    end
    e.rdata = rd(ra, ti, te);
    e.stall = trap | mret;
    e.jen   = !r && mode != 0;
    e.flush = e.jen;
    e.jaddr = !e.jen ? 0 : mode == 1 ? m_tvec : m_epc;
    q.push_back(e);
    if (r) mreset();
    else begin
      old_mie = m_mie; old_mpie = m_mpie;
      if (we && wa == 12'hB00) m_cyc[31:0] = wd;
      else if (we && wa == 12'hB80) m_cyc[63:32] = wd;
      else m_cyc = m_cyc + 1;
      if (we)
        case (wa)
          12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
          12'h304: m_ie = wd & 32'h888;
          12'h305: m_tvec = wd & ~32'h3;
          12'h340: m_scratch = wd;
          12'h341: m_epc = wd & ~32'h3;
          12'h342: m_cause = wd;
          12'h343: m_tval = wd;
          default: ;
        endcase
      if (trap) begin
        m_epc = pc & ~32'h3; m_cause = code; m_tval = 0; m_mpie = old_mie; m_mie = 0;
      end
      if (mret) begin m_mie = old_mpie; m_mpie = 1; end
      mode = trap ? 1 : mret ? 2 : 0;
    end
  endtask

  task automatic rdc(input logic [11:0] ra);
    go(0, ra, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    vectors++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("rdata[%h]", bus.csr_raddr), bus.csr_rdata, e.rdata);
      chk("stallreq", 32'(bus.stallreq), 32'(e.stall));
      chk("flush", 32'(bus.flush), 32'(e.flush));
      chk("jump_en", 32'(bus.trap_jump_enable), 32'(e.jen));
      chk("jump_addr", bus.trap_jump_addr, e.jaddr);
    end
  end

  initial begin
    rst = 1; bus.csr_raddr = 0; bus.csr_we = 0; bus.csr_waddr = 0; bus.csr_wdata = 0;
    bus.exception = 0; bus.inst_valid = 0; bus.inst_addr = 0; bus.irq_timer = 0; bus.irq_ext = 0;
    mreset();
    repeat (2) @(posedge clk);
    go(1, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    rdc(12'h300); rdc(12'h305); rdc(12'h7C0); rdc(12'hF14);
    go(0, 12'h305, 1, 12'h305, 32'h8000_0103, 0, 0, 0, 0, 0);
    rdc(12'h305);
    go(0, 12'h305, 1, 12'h305, 32'h0000_0100, 0, 0, 0, 0, 0);
    go(0, 12'h341, 0, 0, 0, 32'h1, 1, 32'h40, 0, 0);
    go(0, 12'h341, 0, 0, 0, 32'h1, 1, 32'h44, 0, 0);
    rdc(12'h342);
    go(0, 12'h300, 1, 12'h300, 32'h8, 0, 0, 0, 1, 1);
    go(0, 12'h304, 1, 12'h304, 32'h880, 0, 0, 0, 1, 1);
    go(0, 12'h300, 0, 0, 0, 0, 1, 32'h80, 1, 1);
    go(0, 12'h342, 0, 0, 0, 0, 1, 32'h84, 1, 1);
    rdc(12'h300); rdc(12'h342); rdc(12'h341);
    go(0, 12'h341, 1, 12'h341, 32'h44, 0, 0, 0, 0, 0);
    go(0, 12'h300, 0, 0, 0, 32'h8, 1, 32'h90, 0, 0);
    go(0, 12'h300, 0, 0, 0, 0, 1, 32'h94, 0, 0);
    rdc(12'h300);
    go(0, 12'hB00, 0, 0, 0, 0, 0, 0, 1, 0);
    go(0, 12'hB00, 1, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
    go(0, 12'hB80, 1, 12'hB80, 32'h0, 0, 0, 0, 0, 0);
    rdc(12'hB00); rdc(12'hB00); rdc(12'hB80);
    go(0, 12'h300, 0, 0, 0, 32'h2, 1, 32'hA0, 0, 0);
    go(1, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    rdc(12'h300);
    go(0, 12'h300, 0, 0, 0, 32'h6, 1, 32'hB0, 0, 0);
    go(0, 12'h342, 0, 0, 0, 32'h4, 1, 32'hB4, 0, 0);
    rdc(12'h342);
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] ex;
      ex = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom_range(0, 5) == 0 ? 32'h8 : 32'h0);
      go($urandom_range(0, 149) == 0, addrs[$urandom_range(0, 12)], $urandom_range(0, 3) == 0,
         addrs[$urandom_range(0, 12)], $urandom, ex, $urandom_range(0, 3) != 0, $urandom,
         $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    @(negedge clk); #1;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
